writeback_stage: RTL and testbench

Final stage of the RV32I core, directly upstream of the register file. It accepts completed results from execute (ALU, link address, load, no-write) over a valid/ready handshake. For loads it waits for data memory, then aligns and sign- or zero-extends the data. It drives the register file write port from registered outputs, suppresses writes to x0, counts retired instructions, and optionally bypasses same-cycle writes onto the operand read path.

---
 rtl/writeback_stage.sv | 147 ++++++++++++++
 tb/tb_writeback_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: accepts execute results, waits for and extracts load data, drives the
// register file write port and the retire counter. Optional macro WRITEBACK_BYPASS_EN forwards writes to operands.
module writeback_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic [1:0]  result_kind,
    input  logic [4:0]  result_rd,
    input  logic [31:0] result_value,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_address_low,
    input  logic        load_data_valid,
    input  logic [31:0] load_data,
    output logic        write_enable,
    output logic [4:0]  register_write_select,
    output logic [31:0] register_data_write,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] register_data_1,
    input  logic [31:0] register_data_2,
    output logic [31:0] operand_1,
    output logic [31:0] operand_2,
    output logic [31:0] instructions_retired
);

    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_NONE = 2'd3;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e      state_q;
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_addr_low_q;
    logic        write_enable_q;
    logic [4:0]  select_q;
    logic [31:0] data_q;
    logic [31:0] retired_q;
    logic [31:0] load_word_d;

    // Byte/halfword lanes come from the captured address offset; undefined widths pass the word through.
    function automatic logic [31:0] extract_load(input logic [2:0] funct3,
                                                 input logic [1:0] addr_low,
                                                 input logic [31:0] word);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        byte_s = word[{addr_low, 3'b000} +: 8];
        half_s = addr_low[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  extract_load = {{24{byte_s[7]}}, byte_s};
            3'b001:  extract_load = {{16{half_s[15]}}, half_s};
            3'b100:  extract_load = {24'd0, byte_s};
            3'b101:  extract_load = {16'd0, half_s};
            default: extract_load = word;
        endcase
    endfunction

    assign load_word_d           = extract_load(ld_funct3_q, ld_addr_low_q, load_data);
    assign result_ready          = (state_q == IDLE);
    assign write_enable          = write_enable_q;
    assign register_write_select = select_q;
    assign register_data_write   = data_q;
    assign instructions_retired  = retired_q;

    // Handshake FSM with registered write port; write outputs fall back to zero every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ld_rd_q        <= 5'd0;
            ld_funct3_q    <= 3'd0;
            ld_addr_low_q  <= 2'd0;
            write_enable_q <= 1'b0;
            select_q       <= 5'd0;
            data_q         <= 32'd0;
            retired_q      <= 32'd0;
        end else begin
            write_enable_q <= 1'b0;
            select_q       <= 5'd0;
            data_q         <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (result_valid) begin
                        case (result_kind)
                            KIND_LOAD: begin
                                ld_rd_q       <= result_rd;
                                ld_funct3_q   <= load_funct3;
                                ld_addr_low_q <= load_address_low;
                                state_q       <= WAIT_LOAD;
                            end
                            KIND_NONE: begin
                                retired_q <= retired_q + 32'd1;
                            end
                            default: begin
                                if (result_rd != 5'd0) begin
                                    write_enable_q <= 1'b1;
                                    select_q       <= result_rd;
                                    data_q         <= result_value;
                                end
                                retired_q <= retired_q + 32'd1;
                            end
                        endcase
                    end
                end
                WAIT_LOAD: begin
                    if (load_data_valid) begin
                        if (ld_rd_q != 5'd0) begin
                            write_enable_q <= 1'b1;
                            select_q       <= ld_rd_q;
                            data_q         <= load_word_d;
                        end
                        retired_q <= retired_q + 32'd1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    // x0 reads as zero; a write being presented this cycle wins over stale register file data.
    function automatic logic [31:0] bypass(input logic [4:0] rs, input logic [31:0] rdata);
        if (rs == 5'd0) begin
            bypass = 32'd0;
        end else if (write_enable_q && (select_q == rs)) begin
            bypass = data_q;
        end else begin
            bypass = rdata;
        end
    endfunction

    assign operand_1 = bypass(rs1, register_data_1);
    assign operand_2 = bypass(rs2, register_data_2);
`else
    logic unused_rs_s;
    assign unused_rs_s = ^{rs1, rs2};
    assign operand_1   = register_data_1;
    assign operand_2   = register_data_2;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reference model checked every cycle plus literal pins.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic [1:0]  result_kind = 2'd0;
    logic [4:0]  result_rd = 5'd0;
    logic [31:0] result_value = 32'd0;
    logic [2:0]  load_funct3 = 3'd0;
    logic [1:0]  load_address_low = 2'd0;
    logic        load_data_valid = 1'b0;
    logic [31:0] load_data = 32'd0;
    logic        write_enable;
    logic [4:0]  register_write_select;
    logic [31:0] register_data_write;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [31:0] register_data_1 = 32'd0;
    logic [31:0] register_data_2 = 32'd0;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] instructions_retired;

    int n_cmp  = 0;
    int n_fail = 0;

    writeback_stage dut (
        .clock(clock), .reset(reset),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_kind(result_kind), .result_rd(result_rd), .result_value(result_value),
        .load_funct3(load_funct3), .load_address_low(load_address_low),
        .load_data_valid(load_data_valid), .load_data(load_data),
        .write_enable(write_enable), .register_write_select(register_write_select),
        .register_data_write(register_data_write),
        .rs1(rs1), .rs2(rs2), .register_data_1(register_data_1), .register_data_2(register_data_2),
        .operand_1(operand_1), .operand_2(operand_2),
        .instructions_retired(instructions_retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a load of the given width/sign at the given offset must produce.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] al,
                                               input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * al)) & 32'hFF;
        h = (d >> (16 * al[1])) & 32'hFFFF;
        case (f3)
            3'b000:  model_load = (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'b001:  model_load = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  model_load = b;
            3'b101:  model_load = h;
            default: model_load = d;
        endcase
    endfunction

    logic        m_pending = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [2:0]  m_f3 = 3'd0;
    logic [1:0]  m_al = 2'd0;
    logic [31:0] m_ret = 32'd0;
    logic        e_we = 1'b0;
    logic [4:0]  e_sel = 5'd0;
    logic [31:0] e_data = 32'd0;

    // Model advances on each edge from the inputs, then the DUT is compared shortly after.
    always @(posedge clock) begin
        logic [31:0] wv;
        logic        retire;
        logic [4:0]  wrd;
        retire = 1'b0;
        wrd    = 5'd0;
        wv     = 32'd0;
        if (reset) begin
            m_pending = 1'b0;
            m_ret     = 32'd0;
        end else if (!m_pending && result_valid) begin
            if (result_kind == 2'd1) begin
                m_pending = 1'b1;
                m_rd = result_rd; m_f3 = load_funct3; m_al = load_address_low;
            end else begin
                retire = 1'b1;
                if (result_kind != 2'd3) begin
                    wrd = result_rd; wv = result_value;
                end
            end
        end else if (m_pending && load_data_valid) begin
            m_pending = 1'b0;
            retire = 1'b1;
            wrd = m_rd; wv = model_load(m_f3, m_al, load_data);
        end
        if (retire) m_ret = m_ret + 32'd1;
        e_we   = (wrd != 5'd0);
        e_sel  = e_we ? wrd : 5'd0;
        e_data = e_we ? wv : 32'd0;
        #1;
        chk("ready", {31'd0, result_ready}, {31'd0, !m_pending});
        chk("we", {31'd0, write_enable}, {31'd0, e_we});
        chk("sel", {27'd0, register_write_select}, {27'd0, e_sel});
        chk("data", register_data_write, e_data);
        chk("retired", instructions_retired, m_ret);
    end

    task automatic issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] v,
                         input logic [2:0] f3, input logic [1:0] al);
        result_valid = 1'b1; result_kind = k; result_rd = rd; result_value = v;
        load_funct3 = f3; load_address_low = al;
        @(negedge clock);
        result_valid = 1'b0;
    endtask

    task automatic load_return(input int wait_cycles, input logic [31:0] d);
        repeat (wait_cycles) @(negedge clock);
        load_data_valid = 1'b1; load_data = d;
        @(negedge clock);
        load_data_valid = 1'b0;
    endtask

    logic [31:0] ld_words [4] = '{32'h8081_7F01, 32'h00FF_8000, 32'hFEDC_BA98, 32'h1234_5678};
    logic [2:0]  f3_list  [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_ready", {31'd0, result_ready}, 32'd1);
        chk("rst_retired", instructions_retired, 32'd0);

        issue(2'd0, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        chk("alu_we", {31'd0, write_enable}, 32'd1);
        chk("alu_sel", {27'd0, register_write_select}, 32'd5);
        chk("alu_data", register_data_write, 32'h1234_5678);
        chk("alu_retired", instructions_retired, 32'd1);
        @(negedge clock);
        chk("alu_we_drop", {31'd0, write_enable}, 32'd0);

        issue(2'd0, 5'd0, 32'hFFFF_FFFF, 3'd0, 2'd0);
        chk("x0_we", {31'd0, write_enable}, 32'd0);
        chk("x0_retired", instructions_retired, 32'd2);

        // load_data_valid while idle must be ignored.
        load_return(0, 32'hDEAD_BEEF);

        // Back-to-back mixed ALU/LINK/NONE acceptance.
        issue(2'd2, 5'd1, 32'h0000_1004, 3'd0, 2'd0);
        issue(2'd3, 5'd9, 32'h5555_5555, 3'd0, 2'd0);
        issue(2'd0, 5'd31, 32'h8000_0000, 3'd0, 2'd0);
        issue(2'd0, 5'd12, 32'h0BAD_F00D, 3'd0, 2'd0);
        @(negedge clock);

        issue(2'd1, 5'd3, 32'hFFFF_FFFF, 3'b000, 2'd2);
        result_valid = 1'b1; result_kind = 2'd0; result_rd = 5'd9; result_value = 32'h0000_0999;
        for (int i = 0; i < 2; i++) begin
            chk("lb_wait_ready", {31'd0, result_ready}, 32'd0);
            @(negedge clock);
        end
        result_valid = 1'b0;
        chk("lb_wait_ready", {31'd0, result_ready}, 32'd0);
        load_return(0, 32'h0080_0000);
        chk("lb_data", register_data_write, 32'hFFFF_FF80);
        chk("lb_sel", {27'd0, register_write_select}, 32'd3);
        chk("lb_ready", {31'd0, result_ready}, 32'd1);

        issue(2'd1, 5'd4, 32'd0, 3'b101, 2'd2);
        load_return(0, 32'hBEEF_0000);
        chk("lhu_data", register_data_write, 32'h0000_BEEF);

        for (int i = 0; i < 24; i++) begin
            issue(2'd1, 5'(i % 4 == 3 ? 0 : i + 1), 32'd0, f3_list[i % 6], 2'(i % 4));
            load_return(i % 3, ld_words[i % 4]);
        end
        issue(2'd1, 5'd6, 32'd0, 3'b000, 2'd3);
        issue(2'd1, 5'd6, 32'd0, 3'b001, 2'd1);
        load_return(1, 32'h7F00_8001);
        @(negedge clock);

        issue(2'd1, 5'd8, 32'd0, 3'b010, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        load_return(0, 32'hCAFE_CAFE);
        chk("rst_load_we", {31'd0, write_enable}, 32'd0);
        chk("rst_load_retired", instructions_retired, 32'd0);
        chk("rst_load_ready", {31'd0, result_ready}, 32'd1);

        issue(2'd0, 5'd7, 32'hA5A5_A5A5, 3'd0, 2'd0);
        rs1 = 5'd7; register_data_1 = 32'd0; rs2 = 5'd0; register_data_2 = 32'h11;
        #1;
`ifdef WRITEBACK_BYPASS_EN
        chk("byp_op1", operand_1, 32'hA5A5_A5A5);
        chk("byp_op2", operand_2, 32'd0);
        rs1 = 5'd8; register_data_1 = 32'h0000_0042;
        #1;
        chk("byp_op1_miss", operand_1, 32'h0000_0042);
`else
        chk("pass_op1", operand_1, 32'd0);
        chk("pass_op2", operand_2, 32'h11);
`endif
        @(negedge clock);
        rs1 = 5'd7; register_data_1 = 32'h0000_0077;
        #1;
        chk("op1_after_write", operand_1, 32'h0000_0077);
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
